// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_pkg
//  Description : Shared AHB-Lite encodings and bridge request types.
//                state_t    - HTRANS transfer type
//                burst_t    - HBURST burst type
//                size_t     - HSIZE transfer size (bytes = 2**size)
//                response_t - HRESP
//                slv_state_t- data-phase state of the slave front-end
//                bridge_req_t - request record at the default bus widths
//  Revision    : 1.0 - initial release
// ============================================================================
package ahb_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } state_t;

  typedef enum logic [2:0] {
    BURST_SINGLE = 3'd0,
    BURST_INCR   = 3'd1,
    BURST_WRAP4  = 3'd2,
    BURST_INCR4  = 3'd3,
    BURST_WRAP8  = 3'd4,
    BURST_INCR8  = 3'd5,
    BURST_WRAP16 = 3'd6,
    BURST_INCR16 = 3'd7
  } burst_t;

  typedef enum logic [2:0] {
    SIZE_BYTE   = 3'd0,
    SIZE_HALF   = 3'd1,
    SIZE_WORD   = 3'd2,
    SIZE_DWORD  = 3'd3,
    SIZE_4WORD  = 3'd4,
    SIZE_8WORD  = 3'd5,
    SIZE_16WORD = 3'd6,
    SIZE_32WORD = 3'd7
  } size_t;

  typedef enum logic {
    RESP_OKAY  = 1'b0,
    RESP_ERROR = 1'b1
  } response_t;

  // Data-phase state of the previously accepted address phase.
  typedef enum logic [2:0] {
    SLV_IDLE  = 3'd0,
    SLV_WDATA = 3'd1,
    SLV_RREQ  = 3'd2,
    SLV_RWAIT = 3'd3,
    SLV_RDONE = 3'd4,
    SLV_ERR1  = 3'd5,
    SLV_ERR2  = 3'd6
  } slv_state_t;

  localparam int BRIDGE_ADDR_W = 32;
  localparam int BRIDGE_DATA_W = 64;

  // Field order matches the flat packing used on the request FIFO.
  typedef struct packed {
    logic                         write;
    logic [BRIDGE_ADDR_W-1:0]     addr;
    size_t                        size;
    burst_t                       burst;
    logic [BRIDGE_DATA_W-1:0]     wdata;
    logic [BRIDGE_DATA_W/8-1:0]   wstrb;
  } bridge_req_t;

endpackage
`default_nettype wire

// File: rtl/bridge_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : bridge_fifo
//  Description : Synchronous first-word-fall-through FIFO with full/empty
//                flags. A push while full is accepted only together with a
//                pop in the same cycle (count unchanged).
//  Ports       : clk, rst_n (async active-low)
//                push, wdata  - write side
//                pop, rdata   - read side, rdata is the current head
//                full, empty  - occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module bridge_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    // Depth is a power of two, so the pointers wrap naturally.
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: contents are only visible when count is nonzero.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ahb_slave_if.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_slave_if
//  Description : AHB-Lite slave front-end. Each accepted NONSEQ/SEQ beat
//                becomes one request on a valid/ready channel through a
//                small FIFO. Wait states come from a full FIFO or an
//                outstanding read; illegal transfers get a two-cycle ERROR.
//  Ports       : HCLK, HRESETn      - clock, async active-low reset
//                HADDR..HWDATA      - AHB-Lite slave inputs
//                HREADY/HRESP/HRDATA- AHB-Lite slave outputs
//                req_*              - request channel (head of FIFO)
//                rd_valid, rd_data  - read data return pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_slave_if
  import ahb_pkg::*;
#(
  parameter int AHB_DATA_WIDTH    = 64,
  parameter int AHB_ADDRESS_WIDTH = 32,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                           HCLK,
  input  logic                           HRESETn,
  input  logic [AHB_ADDRESS_WIDTH-1:0]   HADDR,
  input  logic [1:0]                     HTRANS,
  input  logic                           HWRITE,
  input  logic [2:0]                     HSIZE,
  input  logic [2:0]                     HBURST,
  input  logic [AHB_DATA_WIDTH-1:0]      HWDATA,
  output logic                           HREADY,
  output logic                           HRESP,
  output logic [AHB_DATA_WIDTH-1:0]      HRDATA,
  output logic                           req_valid,
  input  logic                           req_ready,
  output logic                           req_write,
  output logic [AHB_ADDRESS_WIDTH-1:0]   req_addr,
  output logic [2:0]                     req_size,
  output logic [2:0]                     req_burst,
  output logic [AHB_DATA_WIDTH-1:0]      req_wdata,
  output logic [AHB_DATA_WIDTH/8-1:0]    req_wstrb,
  input  logic                           rd_valid,
  input  logic [AHB_DATA_WIDTH-1:0]      rd_data
);

  localparam int STRB_W = AHB_DATA_WIDTH / 8;
  localparam int LANE_W = $clog2(STRB_W);
  localparam int REQ_W  = 1 + AHB_ADDRESS_WIDTH + 3 + 3 + AHB_DATA_WIDTH + STRB_W;

  slv_state_t                     state_q, state_d;
  logic [AHB_ADDRESS_WIDTH-1:0]   addr_q, addr_d;
  logic [2:0]                     size_q, size_d;
  logic [2:0]                     burst_q, burst_d;
  logic [STRB_W-1:0]              strb_q, strb_d;
  logic [AHB_DATA_WIDTH-1:0]      hrdata_q, hrdata_d;

  logic                           hready_w;
  logic                           addr_valid, addr_legal;
  logic                           size_ok, aligned;
  logic [AHB_ADDRESS_WIDTH-1:0]   align_mask;
  logic [STRB_W-1:0]              strb_calc;
  int                             lower_lane, nbytes;

  logic                           fifo_full, fifo_empty, push, is_write_phase;
  logic [REQ_W-1:0]               push_data, pop_data;

  // HREADY depends on registered state plus fifo_full only.
  always_comb begin
    case (state_q)
      SLV_IDLE, SLV_RDONE, SLV_ERR2: hready_w = 1'b1;
      SLV_WDATA:                     hready_w = !fifo_full;
      default:                       hready_w = 1'b0;
    endcase
  end

  assign HREADY = hready_w;
  assign HRESP  = (state_q == SLV_ERR1) || (state_q == SLV_ERR2);
  assign HRDATA = hrdata_q;

  // Address-phase decode: legality and byte-lane strobes.
  always_comb begin
    addr_valid = hready_w && (HTRANS == TRANS_NONSEQ || HTRANS == TRANS_SEQ);
    size_ok    = (int'(HSIZE) <= LANE_W);
    align_mask = (AHB_ADDRESS_WIDTH'(1) << HSIZE) - AHB_ADDRESS_WIDTH'(1);
    aligned    = ((HADDR & align_mask) == '0);
    addr_legal = size_ok && aligned;
    lower_lane = int'(HADDR[LANE_W-1:0]);
    nbytes     = 1 << HSIZE;
    strb_calc  = '0;
    for (int i = 0; i < STRB_W; i++) begin
      strb_calc[i] = (i >= lower_lane) && (i < lower_lane + nbytes);
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    size_d   = size_q;
    burst_d  = burst_q;
    strb_d   = strb_q;
    hrdata_d = hrdata_q;
    push     = 1'b0;

    // Any cycle completing a data phase also samples the next address phase.
    if (hready_w) begin
      if (addr_valid) begin
        addr_d  = HADDR;
        size_d  = HSIZE;
        burst_d = HBURST;
        strb_d  = HWRITE ? strb_calc : '0;
        if (!addr_legal) begin
          state_d = SLV_ERR1;
        end else if (HWRITE) begin
          state_d = SLV_WDATA;
        end else begin
          state_d = SLV_RREQ;
        end
      end else begin
        state_d = SLV_IDLE;
      end
    end

    case (state_q)
      SLV_WDATA: push = !fifo_full;
      SLV_RREQ: begin
        if (!fifo_full) begin
          push    = 1'b1;
          state_d = SLV_RWAIT;
        end
      end
      SLV_RWAIT: begin
        if (rd_valid) begin
          hrdata_d = rd_data;
          state_d  = SLV_RDONE;
        end
      end
      SLV_ERR1: state_d = SLV_ERR2;
      default: ;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= SLV_IDLE;
      addr_q   <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      strb_q   <= '0;
      hrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      burst_q  <= burst_d;
      strb_q   <= strb_d;
      hrdata_q <= hrdata_d;
    end
  end

  // Writes carry the live HWDATA of the data phase; reads carry no data.
  assign is_write_phase = (state_q == SLV_WDATA);
  assign push_data = {is_write_phase, addr_q, size_q, burst_q,
                      is_write_phase ? HWDATA : {AHB_DATA_WIDTH{1'b0}},
                      strb_q};

  bridge_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .push  (push),
    .wdata (push_data),
    .pop   (req_ready),
    .rdata (pop_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign req_valid = !fifo_empty;
  assign {req_write, req_addr, req_size, req_burst, req_wdata, req_wstrb} = pop_data;

endmodule
`default_nettype wire
